// File: rtl/code_loader_pkg.sv
// Shared definitions for the BPF instruction loader and its host-side driver model.
package code_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Stream word order within one instruction: the high half arrives first.
  localparam bit HI_WORD_FIRST = 1'b1;

endpackage

// File: rtl/code_loader.sv
// Packs a 32-bit word stream into 64-bit instructions and writes them to codemem from address 0.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   prog_len,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_nx;
  logic                  half;
  logic [ADDR_WIDTH:0]   count;
  logic [WORD_WIDTH-1:0] hi;
  logic                  beat;
  logic                  full;

  assign s_ready = (state == ST_LOAD);
  assign busy    = (state == ST_LOAD);
  assign done    = (state == ST_DONE);
  assign err     = (state == ST_ERR);
  assign beat    = s_valid & s_ready;
  assign full    = (count == DEPTH);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (beat) begin
          if (full)        state_nx = ST_ERR;
          else if (s_last) state_nx = half ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR:  if (start) state_nx = ST_LOAD;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half     <= 1'b0;
      count    <= '0;
      hi       <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      prog_len <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            count <= '0;
            half  <= 1'b0;
          end
        end
        ST_LOAD: begin
          // A beat at full depth is an overflow: nothing is latched or written.
          if (beat && !full) begin
            if (!half) begin
              if (!s_last) begin
                hi   <= s_data;
                half <= 1'b1;
              end
            end else begin
              wr_data <= HI_WORD_FIRST ? {hi, s_data} : {s_data, hi};
              wr_addr <= count[ADDR_WIDTH-1:0];
              wr_en   <= 1'b1;
              count   <= count + 1'b1;
              half    <= 1'b0;
              if (s_last) prog_len <= count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Scoreboard bench for code_loader built with a 4-instruction memory to reach the overflow boundary.
module tb_code_loader;
  import code_loader_pkg::*;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 64;
  localparam int unsigned WW    = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, err;
  logic [AW:0]   prog_len;
  logic [WW-1:0] s_data;
  logic          s_valid, s_ready, s_last;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;

  code_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .prog_len(prog_len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  // codemem stand-in for readback
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host-side model of the loader
  logic [AW+DW-1:0] exp_q[$];
  int unsigned      m_count;
  logic             m_half;
  logic [WW-1:0]    m_hi;
  logic             exp_err;
  int unsigned      exp_plen;
  int unsigned      exp_done;
  int unsigned      done_seen;

  task automatic model_beat(input logic [WW-1:0] w, input logic last);
    logic [DW-1:0] d;
    if (m_count == DEPTH) exp_err = 1'b1;
    else if (!m_half) begin
      if (last) exp_err = 1'b1;
      else begin m_hi = w; m_half = 1'b1; end
    end else begin
      d = HI_WORD_FIRST ? {m_hi, w} : {w, m_hi};
      exp_q.push_back({m_count[AW-1:0], d});
      m_count++;
      m_half = 1'b0;
      if (last) begin exp_plen = m_count; exp_done++; end
    end
  endtask

  task automatic model_clear();
    m_count = 0; m_half = 1'b0; exp_err = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (wr_en) begin
      if (exp_q.size() == 0) check("unexpected_write", {62'd0, wr_addr}, 64'hdead);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", {62'd0, wr_addr}, {62'd0, e[AW+DW-1:DW]});
        check("wr_data", wr_data, e[DW-1:0]);
      end
    end
    if (done) done_seen++;
  end

  task automatic pulse_start(input bit takes);
    start = 1'b1;
    @(posedge clk);
    if (takes) model_clear();
    #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input logic last, input int unsigned gap);
    int unsigned n = 0;
    s_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk) check("busy_in_gap", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
    end
    s_data = w; s_last = last; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 20) begin n++; @(negedge clk); end
    check("beat_accepted", {63'd0, s_ready}, 64'd1);
    if (s_ready) begin
      @(posedge clk);
      model_beat(w, last);
    end
    #1 s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_stream(input int unsigned n, input logic [WW-1:0] base,
                             input bit with_last, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++)
      send_word(base + i, with_last && (i == n - 1), gap);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_done_cnt"}, 64'(done_seen), 64'(exp_done));
    check({tag, "_prog_len"}, 64'(prog_len), 64'(exp_plen));
    check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    exp_plen = 0; exp_done = 0; done_seen = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_prog_len", 64'(prog_len), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic two-instruction program
    pulse_start(1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    send_stream(4, 32'hA000_0000, 1, 0);
    settle_and_check("basic");
    check("busy_idle", {63'd0, busy}, 64'd0);

    // Same program with s_valid gaps, then readback
    pulse_start(1);
    send_stream(4, 32'hA000_0000, 1, 1);
    settle_and_check("gaps");
    check("readback0", mem[0], 64'hA000_0000_A000_0001);
    check("readback1", mem[1], 64'hA000_0002_A000_0003);

    // Odd word count: last on the high half
    pulse_start(1);
    send_stream(3, 32'hB000_0000, 1, 0);
    settle_and_check("odd");
    check("odd_s_ready", {63'd0, s_ready}, 64'd0);
    pulse_start(1);
    check("start_clears_err", {63'd0, err}, 64'd0);
    check("restart_busy", {63'd0, busy}, 64'd1);

    // Exactly DEPTH instructions
    send_stream(2 * DEPTH, 32'hC000_0000, 1, 0);
    settle_and_check("full");
    check("full_prog_len4", 64'(prog_len), 64'(DEPTH));

    // Overflow: 9th word with the memory full
    pulse_start(1);
    send_stream(2 * DEPTH + 1, 32'hD000_0000, 0, 0);
    settle_and_check("ovf");
    s_data = 32'hD000_0009; s_valid = 1'b1; s_last = 1'b1;
    repeat (2) begin
      @(negedge clk) check("ovf_s_ready", {63'd0, s_ready}, 64'd0);
    end
    @(posedge clk); #1 s_valid = 1'b0; s_last = 1'b0;

    // Reset in the middle of a load
    pulse_start(1);
    send_stream(3, 32'hE000_0000, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    model_clear(); exp_plen = 0;
    @(negedge clk);
    check("mid_rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_prog_len", 64'(prog_len), 64'd0);
    check("mid_rst_wr_data", wr_data, 64'd0);
    check("mid_rst_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_start(1);
    send_stream(2, 32'hF000_0000, 1, 0);
    settle_and_check("reload");

    // start mid-LOAD is ignored
    pulse_start(1);
    send_stream(2, 32'h1100_0000, 0, 0);
    pulse_start(0);
    send_stream(2, 32'h1100_0002, 1, 0);
    settle_and_check("mid_start");
    check("mid_start_mem1", mem[1], 64'h1100_0002_1100_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
